// File: rtl/dbnc_pkg.sv
// -----------------------------------------------------------------------------
// dbnc_pkg
// Shared constants for the debounce bank:
//   FAST_THRESH - reduced qualification threshold used when FAST_SIM = 1
//   GLITCH_W    - width of each per-channel glitch counter
//   GLITCH_MAX  - saturation value of the glitch counters
// No ports; imported by debounce_ch and debounce_bank.
// -----------------------------------------------------------------------------
package dbnc_pkg;

    localparam int FAST_THRESH = 511;
    localparam int GLITCH_W    = 8;
    localparam int GLITCH_MAX  = 255;

endpackage : dbnc_pkg

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One debounce channel. It has a triple-flop synchroniser and a saturating
// stable-time counter. It drives a debounced level with registered rise/fall
// pulses and a stable flag.
// Optional macro DBNC_GLITCH_CNT_EN adds a saturating glitch counter with a
// synchronous clear.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   din         in   raw asynchronous input
//   glitch_clr  in   synchronous clear of the glitch counter (macro only)
//   glitch_cnt  out  saturating glitch count, GLITCH_W bits (macro only)
//   dout        out  debounced level
//   rise        out  one-cycle pulse on dout 0->1
//   fall        out  one-cycle pulse on dout 1->0
//   stable      out  high while the counter sits at the threshold
// -----------------------------------------------------------------------------
module debounce_ch
    import dbnc_pkg::*;
#(
    parameter int STBL_W   = 16,
    parameter bit FAST_SIM = 1'b0,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din,
`ifdef DBNC_GLITCH_CNT_EN
    input  logic                glitch_clr,
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic                dout,
    output logic                rise,
    output logic                fall,
    output logic                stable
);

    // FAST_SIM only shortens the compare; the counter keeps its full width.
    localparam logic [STBL_W-1:0] THRESH =
        FAST_SIM ? STBL_W'(FAST_THRESH) : {STBL_W{1'b1}};

    logic              r_q1;
    logic              r_q2;
    logic              r_q3;
    logic [STBL_W-1:0] r_cnt;
    logic              r_dout;
    logic              r_rise;
    logic              r_fall;

    logic              w_change;
    logic              w_stable;

    assign w_change = (r_q2 != r_q3);
    assign w_stable = (r_cnt == THRESH);

    // The counter resets to THRESH, so the channel leaves reset already
    // qualified at RST_VAL. No pulse is produced unless q3 later differs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1   <= RST_VAL;
            r_q2   <= RST_VAL;
            r_q3   <= RST_VAL;
            r_cnt  <= THRESH;
            r_dout <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_q1 <= din;
            r_q2 <= r_q1;
            r_q3 <= r_q2;

            if (w_change) begin
                r_cnt <= '0;
            end else if (r_cnt < THRESH) begin
                r_cnt <= r_cnt + STBL_W'(1);
            end

            if (w_stable && (r_q3 != r_dout)) begin
                r_dout <= r_q3;
                r_rise <= r_q3;
                r_fall <= ~r_q3;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
        end
    end

`ifdef DBNC_GLITCH_CNT_EN
    logic                r_glitch;
    logic [GLITCH_W-1:0] r_gcnt;

    // A glitch is a new transition that arrives before the previous level
    // has qualified. Clear takes priority over a simultaneous event.
    always_comb begin
        r_glitch = w_change && (r_cnt < THRESH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gcnt <= '0;
        end else if (glitch_clr) begin
            r_gcnt <= '0;
        end else if (r_glitch && (r_gcnt != GLITCH_W'(GLITCH_MAX))) begin
            r_gcnt <= r_gcnt + GLITCH_W'(1);
        end
    end

    assign glitch_cnt = r_gcnt;
`endif

    assign dout   = r_dout;
    assign rise   = r_rise;
    assign fall   = r_fall;
    assign stable = w_stable;

endmodule : debounce_ch

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// NUM_CH independent debounce channels (cadence, brake, mode buttons). The
// channels sit between the pads and the sensor/control logic.
// Optional macro DBNC_GLITCH_CNT_EN adds per-channel glitch counters and a
// shared synchronous clear.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   din         in   [NUM_CH]    raw asynchronous inputs
//   glitch_clr  in   clear all glitch counters (macro only)
//   dout        out  [NUM_CH]    debounced levels
//   rise        out  [NUM_CH]    one-cycle pulses on dout 0->1
//   fall        out  [NUM_CH]    one-cycle pulses on dout 1->0
//   stable      out  [NUM_CH]    channel counter at threshold
//   glitch_cnt  out  [8*NUM_CH]  glitch counts, channel i at [8i+7:8i]
//                                (macro only)
// -----------------------------------------------------------------------------
module debounce_bank
    import dbnc_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int STBL_W   = 16,
    parameter bit FAST_SIM = 1'b0,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            din,
`ifdef DBNC_GLITCH_CNT_EN
    input  logic                         glitch_clr,
    output logic [GLITCH_W*NUM_CH-1:0]   glitch_cnt,
`endif
    output logic [NUM_CH-1:0]            dout,
    output logic [NUM_CH-1:0]            rise,
    output logic [NUM_CH-1:0]            fall,
    output logic [NUM_CH-1:0]            stable
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        debounce_ch #(
            .STBL_W   (STBL_W),
            .FAST_SIM (FAST_SIM),
            .RST_VAL  (RST_VAL)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .din        (din[gi]),
`ifdef DBNC_GLITCH_CNT_EN
            .glitch_clr (glitch_clr),
            .glitch_cnt (glitch_cnt[gi*GLITCH_W +: GLITCH_W]),
`endif
            .dout       (dout[gi]),
            .rise       (rise[gi]),
            .fall       (fall[gi]),
            .stable     (stable[gi])
        );
    end

endmodule : debounce_bank

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel successor to the single-input cadence filter. Each of `NUM_CH` asynchronous inputs (cadence, brake, mode buttons) passes through a triple-flop synchroniser and a saturating stable-time qualifier. The block produces a debounced level, one-cycle rise/fall pulses and a per-channel stable flag. It sits between the pads and the sensor/control logic and replaces per-signal filter instances.

## Interface
- `NUM_CH`, default 4: number of independent channels.
- `STBL_W`, default 16: stable-counter width; threshold `THRESH = 2^STBL_W - 1`.
- `FAST_SIM`, default 0: when 1, `THRESH = 511` regardless of `STBL_W` (requires `STBL_W >= 9`).
- `RST_VAL`, default 0: reset value of synchroniser flops and `dout`, all channels.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  NUM_CH  raw asynchronous inputs.
- `glitch_clr`  in  1  synchronous clear of all glitch counters (present only with `DBNC_GLITCH_CNT_EN`).
- `dout`  out  NUM_CH  debounced levels.
- `rise`  out  NUM_CH  one-cycle pulse when `dout[i]` goes 0→1.
- `fall`  out  NUM_CH  one-cycle pulse when `dout[i]` goes 1→0.
- `stable`  out  NUM_CH  high while channel counter equals `THRESH`.
- `glitch_cnt`  out  8*NUM_CH  per-channel saturating glitch counts, channel i at bits [8i+7:8i] (present only with `DBNC_GLITCH_CNT_EN`).

## Operation
- Every flop in the block is reset by `rst_n`:
  - `q1`/`q2`/`q3` and `dout` reset to `RST_VAL`.
  - Counters reset to `THRESH`, so channels come out of reset already stable.
  - `rise`, `fall` and `glitch_cnt` reset to 0.
- Per channel, the synchroniser is `q1<=din`, `q2<=q1`, `q3<=q2`.
- Counter `cnt` (STBL_W bits) behaves as follows:
  - If `q2!=q3`, `cnt<=0`.
  - Else if `cnt<THRESH`, `cnt<=cnt+1`.
  - Else it holds at `THRESH`; it never wraps.
- `stable = (cnt==THRESH)`, combinational from the registered `cnt`.
- `dout` is updated as follows:
  - If `stable` and `q3!=dout`: `dout<=q3`, and pulse `rise` or `fall` accordingly on the same edge (registered).
  - Otherwise `dout` holds and both pulses are 0.
- `rise` and `fall` are never both high on one channel, and each lasts exactly one cycle.
- Channels are fully independent. Simultaneous events on different channels are handled in parallel.
- With `FAST_SIM`, the counter is still `STBL_W` wide; only the threshold compare changes.

## Timing
- Let edge 0 be the first `clk` edge sampling a new `din` level that stays steady:
  - `q3` shows the new level after edge 2, and `cnt=0` after edge 2.
  - `cnt=THRESH` after edge `THRESH+2`.
  - `dout`, `rise`/`fall` update on edge `THRESH+3`.
  - `stable` drops after edge 2 and rises after edge `THRESH+2`.
- Any `q2`/`q3` mismatch before `THRESH` is reached restarts the count; `dout` does not change.
- A pulse narrower than one clock may be missed entirely; this is accepted.
- Reset asserted mid-count aborts the count immediately. After release, channels are stable at `RST_VAL`.
- If `din` differs from `RST_VAL` at reset release, `dout` follows after the full latency above.

## Configuration
- Macro `DBNC_GLITCH_CNT_EN`.
- Defined:
  - A glitch event on channel i is `q2!=q3 && cnt<THRESH`, i.e. a new transition before the previous level qualified.
  - `glitch_cnt[i]` increments on each event and saturates at 255.
  - `glitch_clr` high forces all counts to 0 on the next edge; clear wins over a simultaneous event.
- Undefined: the `glitch_clr` and `glitch_cnt` ports and the related logic are absent. All other behaviour is identical.

## Structure
- Package `dbnc_pkg` holds:
  - `FAST_THRESH = 511`
  - `GLITCH_W = 8`
  - `GLITCH_MAX = 255`
- Sub-module `debounce_ch`: one channel (synchroniser, counter, `dout`, pulses, optional glitch counter), instantiated `NUM_CH` times in a generate loop inside `debounce_bank`.

## Test plan
- Reset with `din` = `RST_VAL`: `dout`=`RST_VAL`, `stable`=all 1, and no pulses.
- `FAST_SIM=1`, channel 0 steps 0→1 at edge 0: `dout[0]` and `rise[0]` go high after edge 514. `rise[0]` is high for exactly one cycle, and the other channels are undisturbed.
- `FAST_SIM=1`, channel 1 toggles every 100 cycles for 2000 cycles, then holds 0 (`dout[1]` was 1): `dout[1]` stays 1 throughout the toggling, then `fall[1]` pulses 514 cycles after the last toggle. With the macro defined, `glitch_cnt[1]` equals toggles minus 1.
- All channels step simultaneously: all `dout` and pulse bits change on the same edge.
- Under `DBNC_GLITCH_CNT_EN`, 300 glitches on channel 2: `glitch_cnt[2]`=255. Then assert `glitch_clr` in a cycle that also has a glitch: count reads 0 next cycle.
- `rst_n` asserted at `cnt`=200 mid-qualification: outputs return to reset values asynchronously, no pulse is emitted, and normal latency resumes after release.
